pipe_reg_n: RTL and testbench

Parametrised pipeline register for the pipelined processor, replacing fixed-width per-bit flop banks between stages. Carries a WIDTH-bit payload through DEPTH register stages with a per-stage valid bit. Supports stall (hold all stages) and flush (squash all stages to a bubble). Keeps a saturating count of stalled cycles for performance debug.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_reg_n_if.sv | 31 +++
 rtl/pipe_stage.sv | 52 +++++
 rtl/pipe_reg_n.sv | 73 +++++++
 tb/tb_pipe_reg_n.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline register.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the stall semantics are defined by pipe_ctrl_e.
// Contents: stage-control enum, default bubble payload, control decode helper.
package pipe_pkg;

  // One control word drives every stage, so all stages act in lockstep.
  typedef enum logic [1:0] {
    PIPE_RESET,
    PIPE_FLUSH,
    PIPE_STALL,
    PIPE_ADV
  } pipe_ctrl_e;

  // Widest legal payload; narrower instances take the low bits.
  localparam int unsigned     MAX_WIDTH      = 128;
  localparam logic [MAX_WIDTH-1:0] BUBBLE_DEFAULT = '0;

  // Priority: reset > flush > stall > advance.
  function automatic pipe_ctrl_e decode_ctrl(input logic rst,
                                             input logic flush,
                                             input logic stall);
    pipe_ctrl_e ctrl;
    if (rst)        ctrl = PIPE_RESET;
    else if (flush) ctrl = PIPE_FLUSH;
    else if (stall) ctrl = PIPE_STALL;
    else            ctrl = PIPE_ADV;
    return ctrl;
  endfunction

endpackage

// File: rtl/pipe_reg_n_if.sv
// Bundle of stall/flush/payload inputs and registered outputs of pipe_reg_n.
// Latency: n/a (wires only).
// Backpressure: stall holds the whole pipe; upstream must keep d stable while stalled.
// master: drives stall, flush, d, d_valid; observes q, q_valid, stage_valid, stall_cnt.
// slave:  the pipeline register itself.
interface pipe_reg_n_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) ();

  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stall, flush, d, d_valid,
    input  q, q_valid, stage_valid, stall_cnt
  );

  modport slave (
    input  stall, flush, d, d_valid,
    output q, q_valid, stage_valid, stall_cnt
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: WIDTH-bit payload register plus its valid flop.
// Latency: 1 cycle from d to q when ctrl is PIPE_ADV.
// Backpressure: PIPE_STALL holds payload and valid; PIPE_RESET/PIPE_FLUSH load a bubble.
// Ports: clk, ctrl (decoded stage control), d/d_valid in, q/q_valid out.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  pipe_ctrl_e       ctrl,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d,  vld_q;

  // Payload shifts regardless of valid; consumers qualify with q_valid.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    case (ctrl)
      PIPE_RESET,
      PIPE_FLUSH: begin
        data_d = BUBBLE_VAL;
        vld_d  = 1'b0;
      end
      PIPE_ADV: begin
        data_d = d;
        vld_d  = d_valid;
      end
      default: begin
        data_d = data_q;
        vld_d  = vld_q;
      end
    endcase
  end

  // The synchronous reset arrives already decoded as PIPE_RESET.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    vld_q  <= vld_d;
  end

  assign q       = data_q;
  assign q_valid = vld_q;

endmodule

// File: rtl/pipe_reg_n.sv
// Parametrised DEPTH-stage pipeline register with stall, flush and stall-cycle counter.
// Latency: DEPTH cycles d->q, plus one per stalled cycle; outputs are purely registered.
// Backpressure: stall freezes every stage and drops d; flush squashes all stages to a bubble.
// Ports: clk, reset (sync, active-high), bus (slave modport: stall, flush, d, d_valid,
//        q, q_valid, stage_valid, stall_cnt).
module pipe_reg_n
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter int               DEPTH      = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = BUBBLE_DEFAULT[WIDTH-1:0],
  parameter int               CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  pipe_reg_n_if.slave bus
);

  pipe_ctrl_e       ctrl;
  logic [WIDTH-1:0] stage_dat [DEPTH];
  logic             stage_vld [DEPTH];
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // Decoded once here and fanned out so all stages share one priority decision.
  always_comb begin
    ctrl = decode_ctrl(reset, bus.flush, bus.stall);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_dat;
    logic             in_vld;

    if (i == 0) begin : g_head
      assign in_dat = bus.d;
      assign in_vld = bus.d_valid;
    end else begin : g_body
      assign in_dat = stage_dat[i-1];
      assign in_vld = stage_vld[i-1];
    end

    pipe_stage #(
      .WIDTH      (WIDTH),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk     (clk),
      .ctrl    (ctrl),
      .d       (in_dat),
      .d_valid (in_vld),
      .q       (stage_dat[i]),
      .q_valid (stage_vld[i])
    );

    assign bus.stage_valid[i] = stage_vld[i];
  end

  // Counts only true stall cycles (flush wins over stall); saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl == PIPE_STALL && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.q         = stage_dat[DEPTH-1];
  assign bus.q_valid   = stage_vld[DEPTH-1];
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_n.sv
// Bench for pipe_reg_n: three instances (W5/D1, W8/D3, W5/D2 with a 3-bit counter),
// a vector table on the 3-deep instance, hand sequences for stall/saturation/reset,
// and a random stream checked through an expected-payload queue.
module tb_pipe_reg_n;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_reg_n_if #(.WIDTH(5), .DEPTH(1), .CNT_W(16)) ia ();
  pipe_reg_n_if #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) ib ();
  pipe_reg_n_if #(.WIDTH(5), .DEPTH(2), .CNT_W(3))  ic ();

  pipe_reg_n #(.WIDTH(5), .DEPTH(1), .CNT_W(16)) u_a (.clk(clk), .reset(rst_a), .bus(ia));
  pipe_reg_n #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_b (.clk(clk), .reset(rst_b), .bus(ib));
  pipe_reg_n #(.WIDTH(5), .DEPTH(2), .CNT_W(3))  u_c (.clk(clk), .reset(rst_c), .bus(ic));

  typedef struct {
    logic        rst;
    logic        fl;
    logic        st;
    logic        dv;
    logic [7:0]  d;
    logic [7:0]  eq;
    logic        eqv;
    logic [2:0]  esv;
    logic [15:0] ecnt;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ia.stall = 1'b0; ia.flush = 1'b0; ia.d = '0; ia.d_valid = 1'b0;
    ib.stall = 1'b0; ib.flush = 1'b0; ib.d = '0; ib.d_valid = 1'b0;
    ic.stall = 1'b0; ic.flush = 1'b0; ic.d = '0; ic.d_valid = 1'b0;

    //                rst   fl    st    dv    d        q      qv    sv      cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 8'h00, 1'b0, 3'b001, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 8'h00, 1'b0, 3'b011, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 8'hA1, 1'b1, 3'b111, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hB2, 1'b1, 3'b110, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b1, 3'b100, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hD4, 8'h00, 1'b0, 3'b001, 16'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hE5, 8'h00, 1'b0, 3'b011, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hF6, 8'hD4, 1'b1, 3'b111, 16'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'hD4, 1'b1, 3'b111, 16'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0, 3'b000, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'h00, 1'b0, 3'b001, 16'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 3'b000, 16'd0};

    // Single-stage instance: reset, advance, stall, flush-over-stall.
    rst_a = 1'b1;
    step();
    chk("a_rst_q",   32'(ia.q),           32'h0);
    chk("a_rst_qv",  32'(ia.q_valid),     32'h0);
    chk("a_rst_sv",  32'(ia.stage_valid), 32'h0);
    chk("a_rst_cnt", 32'(ia.stall_cnt),   32'h0);
    rst_a = 1'b0; ia.d = 5'h1F; ia.d_valid = 1'b1;
    step();
    chk("a_adv_q",  32'(ia.q),       32'h1F);
    chk("a_adv_qv", 32'(ia.q_valid), 32'h1);
    ia.stall = 1'b1; ia.d = 5'h00; ia.d_valid = 1'b0;
    step();
    chk("a_stall_q",   32'(ia.q),         32'h1F);
    chk("a_stall_qv",  32'(ia.q_valid),   32'h1);
    chk("a_stall_cnt", 32'(ia.stall_cnt), 32'h1);
    ia.flush = 1'b1;
    step();
    chk("a_flush_q",   32'(ia.q),         32'h0);
    chk("a_flush_qv",  32'(ia.q_valid),   32'h0);
    chk("a_flush_cnt", 32'(ia.stall_cnt), 32'h1);
    ia.flush = 1'b0; ia.stall = 1'b0;

    // Three-stage instance: vector table.
    for (int i = 0; i < 13; i++) begin
      rst_b = tbl[i].rst; ib.flush = tbl[i].fl; ib.stall = tbl[i].st;
      ib.d = tbl[i].d;    ib.d_valid = tbl[i].dv;
      step();
      chk($sformatf("b_vec%0d_q", i),   32'(ib.q),           32'(tbl[i].eq));
      chk($sformatf("b_vec%0d_qv", i),  32'(ib.q_valid),     32'(tbl[i].eqv));
      chk($sformatf("b_vec%0d_sv", i),  32'(ib.stage_valid), 32'(tbl[i].esv));
      chk($sformatf("b_vec%0d_cnt", i), 32'(ib.stall_cnt),   32'(tbl[i].ecnt));
    end
    rst_b = 1'b0;

    // Three-stage instance: random stream against the expected-payload queue.
    rst_b = 1'b1; ib.flush = 1'b0; ib.stall = 1'b0; ib.d_valid = 1'b0;
    step();
    rst_b = 1'b0;
    sb_q.delete();
    for (int n = 0; n < 300; n++) begin
      logic st, fl, dv;
      logic [7:0] dd;
      fl = ($urandom_range(19, 0) == 0);
      st = ($urandom_range(3, 0) == 0);
      dv = ($urandom_range(2, 0) != 0);
      dd = 8'($urandom);
      ib.flush = fl; ib.stall = st; ib.d_valid = dv; ib.d = dd;
      step();
      if (fl) begin
        sb_q.delete();
        chk("b_rnd_flush_qv", 32'(ib.q_valid), 32'h0);
      end else if (!st) begin
        if (dv) sb_q.push_back(dd);
        if (ib.q_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            chk("b_rnd_unexpected_qv", 32'(ib.q_valid), 32'h0);
          end else begin
            chk("b_rnd_q", 32'(ib.q), 32'(sb_q.pop_front()));
          end
        end
      end
    end
    ib.flush = 1'b0; ib.stall = 1'b0; ib.d_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (ib.q_valid === 1'b1) begin
        if (sb_q.size() == 0) chk("b_drain_unexpected_qv", 32'(ib.q_valid), 32'h0);
        else                  chk("b_drain_q", 32'(ib.q), 32'(sb_q.pop_front()));
      end
    end
    chk("b_drain_left", 32'(sb_q.size()), 32'h0);

    // Two-stage instance: stall hold, resume, saturation, reset over stall+flush.
    rst_c = 1'b1;
    step();
    chk("c_rst_cnt", 32'(ic.stall_cnt), 32'h0);
    rst_c = 1'b0; ic.d = 5'b10101; ic.d_valid = 1'b1;
    step();
    ic.d = 5'b11110;
    step();
    chk("c_load_q",  32'(ic.q),           32'(5'b10101));
    chk("c_load_sv", 32'(ic.stage_valid), 32'h3);
    ic.stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ic.d = 5'($urandom); ic.d_valid = 1'($urandom);
      step();
      chk($sformatf("c_hold%0d_q", k),   32'(ic.q),           32'(5'b10101));
      chk($sformatf("c_hold%0d_qv", k),  32'(ic.q_valid),     32'h1);
      chk($sformatf("c_hold%0d_sv", k),  32'(ic.stage_valid), 32'h3);
      chk($sformatf("c_hold%0d_cnt", k), 32'(ic.stall_cnt),   32'(k));
    end
    ic.stall = 1'b0; ic.d = 5'b00011; ic.d_valid = 1'b1;
    step();
    chk("c_resume_q",   32'(ic.q),           32'(5'b11110));
    chk("c_resume_sv",  32'(ic.stage_valid), 32'h3);
    chk("c_resume_cnt", 32'(ic.stall_cnt),   32'h3);
    rst_c = 1'b1;
    step();
    rst_c = 1'b0; ic.stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("c_sat%0d", k), 32'(ic.stall_cnt), (k > 7) ? 32'd7 : 32'(k));
    end
    ic.stall = 1'b0; ic.d = 5'b01010; ic.d_valid = 1'b1;
    step();
    step();
    chk("c_mid_sv", 32'(ic.stage_valid), 32'h3);
    rst_c = 1'b1; ic.stall = 1'b1; ic.flush = 1'b1;
    step();
    chk("c_rst2_sv",  32'(ic.stage_valid), 32'h0);
    chk("c_rst2_qv",  32'(ic.q_valid),     32'h0);
    chk("c_rst2_q",   32'(ic.q),           32'h0);
    chk("c_rst2_cnt", 32'(ic.stall_cnt),   32'h0);
    rst_c = 1'b0; ic.stall = 1'b0; ic.flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
